// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate and parallel load, applied
// once per cycle or as an autonomous multi-cycle burst started by a pulse.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q_out,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             s_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [2:0]       op;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= 3'b000;
      rem_q  <= '0;
      q_out  <= '0;
      s_out  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      rem_q  <= rem_nxt;
      q_out  <= q_nxt;
      s_out  <= s_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state: choose the operation for this edge, then apply it
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    rem_nxt   = rem_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    op        = MODE_HOLD;
    q_nxt     = q_out;
    s_nxt     = s_out;

    case (state)
      IDLE: begin
        if (start) begin
          // The start edge itself performs no register operation
          mode_nxt = mode;
          rem_nxt  = count;
          if ((mode >= MODE_SHL) && (mode <= MODE_ROR) && (count != '0)) begin
            state_nxt = BURST;
            busy_nxt  = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end else begin
          op = mode;
        end
      end
      BURST: begin
        op      = mode_q;
        rem_nxt = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (op)
      MODE_SHL: begin
        q_nxt = {q_out[WIDTH-2:0], s_in};
        s_nxt = q_out[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt = {s_in, q_out[WIDTH-1:1]};
        s_nxt = q_out[0];
      end
      MODE_ROL: begin
        q_nxt = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
        s_nxt = q_out[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt = {q_out[0], q_out[WIDTH-1:1]};
        s_nxt = q_out[0];
      end
      MODE_LOAD: q_nxt = d_in;
      default: ;
    endcase
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with a burst-shift engine. It supports hold, logical shift left/right, rotate left/right and parallel load, either as one operation per cycle or as an autonomous multi-cycle burst started by a `start` pulse. It generalises the team's 4-bit serial-in shift register for use in serialisers, deserialisers and bit-manipulation datapaths.

## Interface
Parameters:
- `WIDTH`, default 8: register width, must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the burst count (derived; do not override).

Ports:
- `clk`  input  1  Clock; all state updates on the rising edge.
- `rst`  input  1  Reset, asynchronous, active-low (0 = reset).
- `mode`  input  3  Operation select:
  - 000: hold
  - 001: shift left (`s_in` enters bit 0)
  - 010: shift right (`s_in` enters bit WIDTH-1)
  - 011: rotate left
  - 100: rotate right
  - 101: parallel load
  - 110/111: hold
- `s_in`  input  1  Serial input bit for the shift modes.
- `d_in`  input  WIDTH  Parallel load data.
- `start`  input  1  Burst request, sampled only in IDLE.
- `count`  input  CNT_W  Number of burst steps.
- `q_out`  output  WIDTH  Register contents.
- `s_out`  output  1  Last bit shifted or rotated out.
- `busy`  output  1  High while a burst is in progress.
- `done`  output  1  One-cycle pulse when a burst completes.

## Operation
- FSM has two states: IDLE and BURST. Reset enters IDLE.
- **IDLE, `start`=0:** apply `mode` once per clock edge.
- **IDLE, `start`=1:** no register operation is performed at this edge. The FSM latches `mode` and `count`:
  - If the latched mode is a shift or rotate (001–100) and `count` ≠ 0, go to BURST with the remaining count set to `count`.
  - Otherwise, stay in IDLE, assert `done` for the next cycle, and leave `q_out`/`s_out` unchanged.
- **BURST:** each edge applies the latched mode once and decrements the remaining count.
  - `s_in` is sampled live each cycle.
  - `mode`, `start`, `count` and `d_in` are ignored.
  - On the edge that applies the last step, return to IDLE and assert `done`.
- Shift left: `q ← {q[WIDTH-2:0], s_in}`, `s_out ← q[WIDTH-1]`.
- Shift right: `q ← {s_in, q[WIDTH-1:1]}`, `s_out ← q[0]`.
- Rotate left: `q ← {q[WIDTH-2:0], q[WIDTH-1]}`, `s_out ← q[WIDTH-1]`.
- Rotate right: `q ← {q[0], q[WIDTH-1:1]}`, `s_out ← q[0]`.
- Load: `q ← d_in`; `s_out` unchanged. Hold: nothing changes.
- `count` may exceed `WIDTH`. Every step executes; a full shift sequence simply flushes the register with `s_in` values.

## Timing
- Reset values: `q_out`=0, `s_out`=0, `busy`=0, `done`=0, FSM=IDLE, latched mode/count=0.
- Reset acts immediately and asynchronously, including mid-burst: the burst is aborted, no `done` is produced, and the FSM returns to IDLE.
- Single-step operations: `q_out` is updated one edge after `mode` is sampled (latency 1).
- Burst with `start` sampled at edge k and `count`=N:
  - `busy` is 1 from after edge k to after edge k+N.
  - Steps occur at edges k+1 … k+N.
  - `done`=1 for exactly the cycle after edge k+N; `busy` falls at the same edge.
- Degenerate start (hold/load/invalid mode, or `count`=0): `done`=1 for the cycle after edge k; `busy` never rises.
- `done` and `busy` are registered outputs; never high simultaneously.
- A new `start` is accepted in the cycle `done` is high (FSM is IDLE).

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with random inputs → `q_out`=0x00, `s_out`=0, `busy`=0, `done`=0 throughout.
- **Load then shift:** `mode`=101, `d_in`=0xA5 for 1 cycle → `q_out`=0xA5. Then `mode`=001, `s_in`=1 for 1 cycle → `q_out`=0x4B, `s_out`=1. Then `mode`=010, `s_in`=0 → `q_out`=0x25, `s_out`=1.
- **Rotate:** load 0x81, then `mode`=100 → `q_out`=0xC0, `s_out`=1. Then `mode`=011 → `q_out`=0x81, `s_out`=1.
- **Burst:** load 0x01, then `start`=1, `mode`=011, `count`=3. Drive `mode`=101 during the burst → `busy` is high 3 cycles, `q_out` goes 0x02, 0x04, 0x08, then `done` pulses once; the load is ignored.
- **Degenerate start:** `start`=1 with `count`=0, and separately with `mode`=101 and `count`=5 → `done` pulses the next cycle, `busy` stays 0, `q_out` is unchanged.
- **Reset and re-start:** start a burst with `count`=10 on 0xFF (shift left, `s_in`=0). Pulse `start` again during the burst → the second start is ignored. Assert `rst`=0 after 4 steps (`q_out`=0xF0) → `q_out`=0, `busy`=0 immediately, no `done`.
